// File: rtl/gru_sequence_controller.sv
// gru_sequence_controller
// Steps a GRU cell through an input sequence of 1..T_MAX timesteps. For each
// step it fetches x_t from the feature buffer, launches the cell, waits for
// completion with a timeout, and feeds h_t back as the next h_prev.
// Per-step results are reported, and a final done pulse marks the end.
module gru_sequence_controller #(
    parameter int D              = 64,
    parameter int H              = 16,
    parameter int DATA_WIDTH     = 26,
    parameter int T_MAX          = 256,
    parameter int TS_WIDTH       = 9,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [TS_WIDTH-1:0]      seq_len,
    input  logic                     init_zero,
    input  logic                     abort,
    output logic                     x_req,
    output logic [TS_WIDTH-1:0]      x_idx,
    input  logic                     x_valid,
    input  logic [D*DATA_WIDTH-1:0]  x_data,
    output logic                     gru_start,
    output logic [D*DATA_WIDTH-1:0]  gru_x,
    output logic [H*DATA_WIDTH-1:0]  gru_h_prev,
    input  logic                     gru_done,
    input  logic [H*DATA_WIDTH-1:0]  gru_h_t,
    output logic                     step_valid,
    output logic [TS_WIDTH-1:0]      step_idx,
    output logic [H*DATA_WIDTH-1:0]  step_h,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TS_WIDTH-1:0]  T_MAX_TS = TS_WIDTH'(T_MAX);
    localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    state_t                    state_q,      state_d;
    logic [TS_WIDTH-1:0]       seq_len_q,    seq_len_d;
    logic [TS_WIDTH-1:0]       x_idx_q,      x_idx_d;
    logic [D*DATA_WIDTH-1:0]   gru_x_q,      gru_x_d;
    logic [H*DATA_WIDTH-1:0]   h_prev_q,     h_prev_d;
    logic [H*DATA_WIDTH-1:0]   step_h_q,     step_h_d;
    logic [TS_WIDTH-1:0]       step_idx_q,   step_idx_d;
    logic                      step_valid_q, step_valid_d;
    logic                      done_q,       done_d;
    logic                      error_q,      error_d;
    logic [CNT_W-1:0]          tmo_cnt_q,    tmo_cnt_d;

    // State register and datapath flops; reset returns every output to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seq_len_q    <= '0;
            x_idx_q      <= '0;
            gru_x_q      <= '0;
            h_prev_q     <= '0;
            step_h_q     <= '0;
            step_idx_q   <= '0;
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            seq_len_q    <= seq_len_d;
            x_idx_q      <= x_idx_d;
            gru_x_q      <= gru_x_d;
            h_prev_q     <= h_prev_d;
            step_h_q     <= step_h_d;
            step_idx_q   <= step_idx_d;
            step_valid_q <= step_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    // and discards any pending commit, step or done pulse.
    always_comb begin
        state_d      = state_q;
        seq_len_d    = seq_len_q;
        x_idx_d      = x_idx_q;
        gru_x_d      = gru_x_q;
        h_prev_d     = h_prev_q;
        step_h_d     = step_h_q;
        step_idx_d   = step_idx_q;
        step_valid_d = 1'b0;
        done_d       = 1'b0;
        error_d      = error_q;
        tmo_cnt_d    = tmo_cnt_q;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        error_d = 1'b0;
                        if (seq_len == '0) begin
                            state_d = DONE;
                        end else begin
                            seq_len_d = (seq_len > T_MAX_TS) ? T_MAX_TS : seq_len;
                            if (init_zero) h_prev_d = '0;
                            x_idx_d   = '0;
                            state_d   = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (x_valid) begin
                        gru_x_d = x_data;
                        state_d = LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (gru_done) begin
                        state_d = UPDATE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    h_prev_d     = gru_h_t;
                    step_h_d     = gru_h_t;
                    step_idx_d   = x_idx_q;
                    step_valid_d = 1'b1;
                    // seq_len_q is never zero here, so the subtraction cannot wrap
                    if (x_idx_q == seq_len_q - TS_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        x_idx_d = x_idx_q + TS_WIDTH'(1);
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign x_req      = (state_q == FETCH);
    assign gru_start  = (state_q == LAUNCH);
    assign busy       = (state_q != IDLE);
    assign x_idx      = x_idx_q;
    assign gru_x      = gru_x_q;
    assign gru_h_prev = h_prev_q;
    assign step_valid = step_valid_q;
    assign step_idx   = step_idx_q;
    assign step_h     = step_h_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_gru_sequence_controller.sv
// Testbench for gru_sequence_controller: a behavioural feature buffer and GRU
// cell respond to the DUT, a scoreboard predicts every step result at launch
// time, and a table of sequence runs plus hand-written corner sequences check
// counts, latencies, timeout, abort and reset behaviour.
module tb_gru_sequence_controller;

    localparam int D    = 4;
    localparam int H    = 2;
    localparam int DW   = 26;
    localparam int TMAX = 8;
    localparam int TSW  = 4;
    localparam int TMO  = 16;
    localparam int XW   = D * DW;
    localparam int HW   = H * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [TSW-1:0] seq_len = '0;
    logic           init_zero = 1'b0;
    logic           abort = 1'b0;
    logic           x_req;
    logic [TSW-1:0] x_idx;
    logic           x_valid = 1'b0;
    logic [XW-1:0]  x_data = '0;
    logic           gru_start;
    logic [XW-1:0]  gru_x;
    logic [HW-1:0]  gru_h_prev;
    logic           gru_done = 1'b0;
    logic [HW-1:0]  gru_h_t = '0;
    logic           step_valid;
    logic [TSW-1:0] step_idx;
    logic [HW-1:0]  step_h;
    logic           busy;
    logic           done;
    logic           error;

    gru_sequence_controller #(
        .D(D), .H(H), .DATA_WIDTH(DW), .T_MAX(TMAX), .TS_WIDTH(TSW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .init_zero(init_zero),
        .abort(abort), .x_req(x_req), .x_idx(x_idx), .x_valid(x_valid), .x_data(x_data),
        .gru_start(gru_start), .gru_x(gru_x), .gru_h_prev(gru_h_prev), .gru_done(gru_done),
        .gru_h_t(gru_h_t), .step_valid(step_valid), .step_idx(step_idx), .step_h(step_h),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TSW-1:0] idx;
        logic [HW-1:0]  h;
    } sb_t;

    typedef struct {
        int len;
        bit iz;
        int stall_idx;
        int stall_n;
        int lat;
        int exp_steps;
        int exp_lat;
    } vec_t;

    sb_t           sb_q[$];
    vec_t          tbl[6];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc = 0, start_cyc = 0, done_cyc = 0;
    int            launches = 0, steps = 0, dones = 0;
    int            tag = 0, m_idx = 0;
    logic [HW-1:0] model_h = '0;
    int            cell_lat = 5, cell_cnt = 0;
    bit            cell_en = 1'b1;
    logic [HW-1:0] cell_h = '0;
    int            stall_idx = 0, stall_left = 0;

    function automatic logic [XW-1:0] xvec(input int t, input int idx);
        logic [XW-1:0] v;
        v = '0;
        for (int i = 0; i < D; i++) v[i*DW +: DW] = DW'(t * 4096 + idx * 64 + i * 7 + 3);
        return v;
    endfunction

    function automatic logic [HW-1:0] cell_fn(input logic [XW-1:0] x, input logic [HW-1:0] hp);
        logic [HW-1:0] h;
        logic [DW-1:0] a, b, p;
        h = '0;
        for (int j = 0; j < H; j++) begin
            a = x[j*DW +: DW];
            b = x[((j + H) % D)*DW +: DW];
            p = hp[j*DW +: DW];
            h[j*DW +: DW] = (a + b) ^ {p[DW-2:0], p[DW-1]} ^ DW'(j + 1);
        end
        return h;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: sample the DUT at the falling edge, run the scoreboard, then
    // drive the buffer and cell responses for the next rising edge.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (gru_start) begin
            launches++;
            check("launch_x", gru_x, xvec(tag, m_idx));
            check("launch_h_prev", gru_h_prev, model_h);
            e.idx = TSW'(m_idx);
            e.h   = cell_fn(xvec(tag, m_idx), model_h);
            sb_q.push_back(e);
            m_idx++;
        end
        if (step_valid) begin
            steps++;
            check("step_expected", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("step_idx", step_idx, e.idx);
                check("step_h", step_h, e.h);
                model_h = e.h;
            end
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            check("busy_at_done", busy, 0);
        end
        // feature buffer with optional backpressure on one step
        if (x_req && int'(x_idx) == stall_idx && stall_left > 0) begin
            check("stall_x_idx", x_idx, stall_idx);
            x_valid = 1'b0;
            stall_left--;
        end else begin
            x_valid = x_req;
        end
        x_data = xvec(tag, int'(x_idx));
        // cell: drops stale done on launch, raises done cell_lat cycles later
        if (gru_start) begin
            cell_cnt = cell_lat;
            gru_done = 1'b0;
            cell_h   = cell_fn(gru_x, gru_h_prev);
        end else if (cell_cnt > 0) begin
            cell_cnt--;
            if (cell_cnt == 0 && cell_en) begin
                gru_done = 1'b1;
                gru_h_t  = cell_h;
            end
        end
    endtask

    task automatic start_seq(input int len, input bit iz);
        tag++;
        m_idx = 0;
        if (iz && len != 0) model_h = '0;
        start     = 1'b1;
        seq_len   = TSW'(len);
        init_zero = iz;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = dones;
        n  = 0;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", dones - d0, 1);
    endtask

    task automatic check_zero_outputs(input string tagname);
        check({tagname, "_x_req"}, x_req, 0);
        check({tagname, "_gru_start"}, gru_start, 0);
        check({tagname, "_step_valid"}, step_valid, 0);
        check({tagname, "_busy"}, busy, 0);
        check({tagname, "_done"}, done, 0);
        check({tagname, "_error"}, error, 0);
        check({tagname, "_x_idx"}, x_idx, 0);
        check({tagname, "_step_idx"}, step_idx, 0);
        check({tagname, "_gru_x"}, gru_x, 0);
        check({tagname, "_gru_h_prev"}, gru_h_prev, 0);
        check({tagname, "_step_h"}, step_h, 0);
    endtask

    initial begin
        int l0, s0, d0, n;

        // len, init_zero, stall_idx, stall_n, cell latency, steps, start-to-done cycles
        tbl[0] = '{3,  1'b1, 0, 0, 5,  3, 26};  // basic run
        tbl[1] = '{3,  1'b1, 1, 7, 5,  3, 33};  // backpressure on step 1
        tbl[2] = '{2,  1'b0, 0, 0, 1,  2, 10};  // continue from previous h
        tbl[3] = '{12, 1'b1, 0, 0, 2,  8, 42};  // seq_len clamped to T_MAX
        tbl[4] = '{1,  1'b1, 0, 0, 15, 1, 20};  // done on last cycle before timeout
        tbl[5] = '{0,  1'b1, 0, 0, 5,  0, 2};   // empty sequence

        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            cell_lat   = tbl[k].lat;
            stall_idx  = tbl[k].stall_idx;
            stall_left = tbl[k].stall_n;
            l0 = launches; s0 = steps;
            start_seq(tbl[k].len, tbl[k].iz);
            wait_done(300);
            check($sformatf("row%0d_latency", k), done_cyc - start_cyc, tbl[k].exp_lat);
            check($sformatf("row%0d_steps", k), steps - s0, tbl[k].exp_steps);
            check($sformatf("row%0d_launches", k), launches - l0, tbl[k].exp_steps);
            check($sformatf("row%0d_sb_empty", k), sb_q.size(), 0);
            check($sformatf("row%0d_error", k), error, 0);
            tick();
            tick();
        end

        // timeout: cell never completes
        cell_en = 1'b0; cell_lat = 5; stall_left = 0;
        l0 = launches; d0 = dones;
        start_seq(2, 1'b1);
        n = 0;
        while (!error && n < 100) begin tick(); n++; end
        check("tmo_cycle", cyc - start_cyc, 19);
        check("tmo_busy", busy, 0);
        check("tmo_no_done", dones - d0, 0);
        check("tmo_launches", launches - l0, 1);
        sb_q.delete();
        tick();
        check("tmo_error_sticky", error, 1);
        cell_en = 1'b1;
        start_seq(1, 1'b1);
        check("tmo_error_cleared", error, 0);
        wait_done(100);
        tick();

        // abort while waiting on step 2 of 4
        l0 = launches; s0 = steps; d0 = dones;
        start_seq(4, 1'b1);
        n = 0;
        while (launches - l0 < 3 && n < 200) begin tick(); n++; end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        repeat (10) tick();
        check("abort_no_done", dones - d0, 0);
        check("abort_steps", steps - s0, 2);
        check("abort_h_prev", gru_h_prev, model_h);
        check("abort_error", error, 0);
        sb_q.delete();
        l0 = launches;
        start_seq(1, 1'b0);
        wait_done(100);
        check("resume_launches", launches - l0, 1);
        tick();

        // reset asserted in UPDATE
        l0 = launches;
        start_seq(3, 1'b1);
        n = 0;
        while (launches == l0 && n < 100) begin tick(); n++; end
        n = 0;
        while (!gru_done && n < 100) begin tick(); n++; end
        tick();
        rst = 1'b1;
        tick();
        check_zero_outputs("midrst");
        rst = 1'b0;
        gru_done = 1'b0; cell_cnt = 0;
        sb_q.delete();
        model_h = '0;
        tick();

        // start while busy is ignored
        s0 = steps;
        start_seq(2, 1'b1);
        repeat (3) tick();
        start = 1'b1; seq_len = TSW'(5); init_zero = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        check("busy_start_ignored", steps - s0, 2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
